// File: rtl/emu_state_link.sv
// emu_state_link: UART endpoint that loads INPUTS_STATE from 2-byte requests and returns a 7-byte OUTPUTS_STATE snapshot
module emu_state_link #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT_BITS  = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RX,
  output logic        TX,
  input  logic [51:0] OUTPUTS_STATE,
  output logic [13:0] INPUTS_STATE,
  output logic        FRAME_ERR,
  output logic        BUSY
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TO_LIM = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_LIM + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_t;
  uart_st_t rx_st, tx_st;
  logic rx_m, rx_s, rx_q;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [2:0] rx_bit, tx_bit, tx_byte;
  logic [7:0] rx_sh, byte0;
  logic byte_idx, pending, tx_r;
  logic [TW-1:0] to_cnt;
  logic [SW-1:0] settle;
  logic [55:0] tx_buf;
  logic rx_tick, tx_tick, req_done, snap;
  assign rx_tick = rx_cnt == (rx_st == START ? HALF : BIT_END);
  assign tx_tick = tx_cnt == BIT_END;
  assign req_done = rx_st == STOP && rx_tick && rx_s && byte_idx;
  // a request landing this cycle restarts the settle window, so it wins over the snapshot
  assign snap = pending && !req_done && settle == SW'(SETTLE_CYCLES) && tx_st == IDLE;
  assign TX = tx_r;
  assign BUSY = pending || tx_st != IDLE;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      {rx_q, rx_s, rx_m} <= 3'b111;
      rx_st <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      byte0 <= '0;
      byte_idx <= 1'b0;
      to_cnt <= '0;
      FRAME_ERR <= 1'b0;
      INPUTS_STATE <= '0;
    end else begin
      {rx_q, rx_s, rx_m} <= {rx_s, rx_m, RX};
      FRAME_ERR <= 1'b0;
      rx_cnt <= (rx_st == IDLE || rx_tick) ? '0 : rx_cnt + CW'(1);
      to_cnt <= (rx_st == IDLE && byte_idx) ? to_cnt + TW'(1) : '0;
      case (rx_st)
        IDLE: begin
          if (rx_q && !rx_s) rx_st <= START;
          else if (byte_idx && to_cnt == TW'(TO_LIM - 1)) byte_idx <= 1'b0;
        end
        START: if (rx_tick) begin
          rx_st <= rx_s ? IDLE : DATA;
          rx_bit <= '0;
        end
        DATA: if (rx_tick) begin
          rx_sh <= {rx_s, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st <= STOP;
        end
        STOP: if (rx_tick) begin
          rx_st <= IDLE;
          if (!rx_s) begin
            FRAME_ERR <= 1'b1;
            byte_idx <= 1'b0;
          end else if (!byte_idx) begin
            byte0 <= rx_sh;
            byte_idx <= 1'b1;
          end else begin
            INPUTS_STATE <= {rx_sh[5:0], byte0};
            byte_idx <= 1'b0;
          end
        end
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pending <= 1'b0;
      settle <= '0;
      tx_st <= IDLE;
      tx_r <= 1'b1;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_byte <= '0;
      tx_buf <= '0;
    end else begin
      if (req_done) begin
        pending <= 1'b1;
        settle <= SW'(1);
      end else if (settle != SW'(SETTLE_CYCLES)) begin
        settle <= settle + SW'(1);
      end
      if (snap) pending <= 1'b0;
      tx_cnt <= (tx_st == IDLE || tx_tick) ? '0 : tx_cnt + CW'(1);
      case (tx_st)
        IDLE: if (snap) begin
          tx_buf <= {4'h0, OUTPUTS_STATE};
          tx_st <= START;
          tx_r <= 1'b0;
          tx_byte <= '0;
        end
        START: if (tx_tick) begin
          tx_st <= DATA;
          tx_r <= tx_buf[0];
          tx_bit <= '0;
        end
        DATA: if (tx_tick) begin
          tx_buf <= tx_buf >> 1;
          tx_bit <= tx_bit + 3'd1;
          tx_r <= tx_bit == 3'd7 ? 1'b1 : tx_buf[1];
          if (tx_bit == 3'd7) tx_st <= STOP;
        end
        STOP: if (tx_tick) begin
          tx_st <= tx_byte == 3'd6 ? IDLE : START;
          tx_r <= tx_byte == 3'd6;
          tx_byte <= tx_byte + 3'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_emu_state_link.sv
// tb_emu_state_link: randomized request/response checks of emu_state_link against a byte-level model
module tb_emu_state_link;
  localparam int CPB = 4;
  localparam int SET = 2;
  localparam int TOB = 32;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic RX = 1'b1;
  logic TX;
  logic [51:0] OUTPUTS_STATE;
  logic [13:0] INPUTS_STATE;
  logic FRAME_ERR, BUSY;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int busy_drop = 0;
  logic out_mode = 1'b0;
  logic [23:0] salt = '0;
  logic [13:0] d = '0;
  logic [7:0] mb;
  logic [7:0] mon_q[$];
  int start_q[$];

  emu_state_link #(.CLKS_PER_BIT(CPB), .SETTLE_CYCLES(SET), .TIMEOUT_BITS(TOB)) dut (
    .CLK(CLK), .RST_N(RST_N), .RX(RX), .TX(TX), .OUTPUTS_STATE(OUTPUTS_STATE),
    .INPUTS_STATE(INPUTS_STATE), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    d <= INPUTS_STATE;
  end
  always @(negedge CLK) if (FRAME_ERR === 1'b1) fe_cnt <= fe_cnt + 1;
  assign OUTPUTS_STATE = out_mode ? {salt, d, ~d} : 52'h1234_5678_9ABC_D;

  // expected 56-bit response for a board whose outputs follow inputs v
  function automatic logic [55:0] resp(input logic [13:0] v);
    return out_mode ? {4'h0, salt, v, ~v} : {4'h0, 52'h1234_5678_9ABC_D};
  endfunction

  initial forever begin
    @(negedge CLK);
    if (TX === 1'b0) begin
      start_q.push_back(cyc);
      repeat (CPB / 2) @(negedge CLK);
      if (BUSY !== 1'b1) busy_drop++;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge CLK);
        mb[i] = TX;
        if (BUSY !== 1'b1) busy_drop++;
      end
      repeat (CPB) @(negedge CLK);
      checks++;
      if (TX !== 1'b1) begin
        errors++;
        $display("FAIL tx_stop_bit: got %b, want 1", TX);
      end
      mon_q.push_back(mb);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RX = stop;
    repeat (CPB) @(negedge CLK);
    RX = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    RX = 1'b1;
    repeat (n * CPB) @(negedge CLK);
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int t = 0;
    while (mon_q.size() < n && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    checks++;
    if (mon_q.size() < n) begin
      errors++;
      $display("FAIL %s_bytes: got %0d bytes, want %0d", tag, mon_q.size(), n);
    end
  endtask

  task automatic check_resp(input logic [55:0] exp, input string tag);
    logic [7:0] got;
    for (int i = 0; i < 7; i++) begin
      got = mon_q.size() > 0 ? mon_q.pop_front() : 8'hxx;
      checks++;
      if (got !== exp[8*i +: 8]) begin
        errors++;
        $display("FAIL %s_byte%0d: got %h, want %h", tag, i, got, exp[8*i +: 8]);
      end
    end
  endtask

  task automatic check_inputs(input logic [13:0] exp, input string tag);
    checks++;
    if (INPUTS_STATE !== exp) begin
      errors++;
      $display("FAIL %s_inputs: got %h, want %h", tag, INPUTS_STATE, exp);
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks += 3;
    if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, want 1", TX); end
    if (INPUTS_STATE !== 14'h0) begin errors++; $display("FAIL reset_inputs: got %h, want 0000", INPUTS_STATE); end
    if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", BUSY); end
    RST_N = 1'b1;
    idle_bits(4);
    checks += 2;
    if (fe_cnt != 0) begin errors++; $display("FAIL reset_frame_err: got %0d pulses, want 0", fe_cnt); end
    if (TX !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL reset_idle: got tx=%b busy=%b, want 1/0", TX, BUSY); end
  endtask

  task automatic test_basic;
    int bd = busy_drop;
    out_mode = 1'b0;
    start_q.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3F, 1'b1);
    idle_bits(1);
    check_inputs(14'h3FA5, "basic");
    wait_bytes(7, "basic");
    check_resp(resp(14'h3FA5), "basic");
    for (int i = 1; i < 7 && i < start_q.size(); i++) begin
      checks++;
      if (start_q[i] - start_q[i-1] != 10 * CPB) begin
        errors++;
        $display("FAIL basic_byte_len%0d: got %0d cycles, want %0d", i, start_q[i] - start_q[i-1], 10 * CPB);
      end
    end
    checks++;
    if (busy_drop != bd) begin errors++; $display("FAIL basic_busy_high: got %0d low samples, want 0", busy_drop - bd); end
    idle_bits(2);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b, want 0", BUSY); end
  endtask

  task automatic test_settle;
    out_mode = 1'b1;
    salt = 24'($urandom);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    idle_bits(1);
    check_inputs(14'h0000, "settle");
    wait_bytes(7, "settle");
    checks++;
    if (mon_q.size() > 0 && mon_q[0] !== 8'hFF) begin
      errors++;
      $display("FAIL settle_first_byte: got %h, want ff", mon_q[0]);
    end
    check_resp(resp(14'h0000), "settle");
    idle_bits(2);
  endtask

  task automatic test_frame_err;
    int f0 = fe_cnt;
    send_byte(8'h12, 1'b0);
    idle_bits(2);
    send_byte(8'h34, 1'b1);
    send_byte(8'h01, 1'b1);
    idle_bits(1);
    checks++;
    if (fe_cnt - f0 != 1) begin errors++; $display("FAIL frame_err_pulses: got %0d, want 1", fe_cnt - f0); end
    check_inputs(14'h0134, "frame_err");
    wait_bytes(7, "frame_err");
    check_resp(resp(14'h0134), "frame_err");
    idle_bits(2);
  endtask

  task automatic test_timeout;
    send_byte(8'h55, 1'b1);
    idle_bits(TOB + 1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h02, 1'b1);
    idle_bits(1);
    check_inputs(14'h0211, "timeout");
    wait_bytes(7, "timeout");
    check_resp(resp(14'h0211), "timeout");
    idle_bits(2);
  endtask

  task automatic test_random;
    logic [7:0] b0, b1;
    for (int n = 0; n < 6; n++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      salt = 24'($urandom);
      send_byte(b0, 1'b1);
      send_byte(b1, 1'b1);
      idle_bits(1);
      check_inputs({b1[5:0], b0}, "random");
      wait_bytes(7, "random");
      check_resp(resp({b1[5:0], b0}), "random");
      idle_bits(2);
    end
  endtask

  task automatic test_coalesce;
    logic [7:0] b[6];
    logic [13:0] v1, v3;
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    v1 = {b[1][5:0], b[0]};
    v3 = {b[5][5:0], b[4]};
    for (int i = 0; i < 6; i++) send_byte(b[i], 1'b1);
    idle_bits(1);
    check_inputs(v3, "coalesce");
    wait_bytes(14, "coalesce");
    check_resp(resp(v1), "coalesce_r1");
    check_resp(resp(v3), "coalesce_r2");
    idle_bits(40);
    checks += 2;
    if (mon_q.size() != 0) begin errors++; $display("FAIL coalesce_extra: got %0d extra bytes, want 0", mon_q.size()); end
    if (BUSY !== 1'b0) begin errors++; $display("FAIL coalesce_busy_end: got %b, want 0", BUSY); end
  endtask

  task automatic test_reset_mid;
    int t = 0;
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    wait_bytes(3, "reset_mid");
    while (TX !== 1'b0 && t < 200) begin
      @(negedge CLK);
      t++;
    end
    @(negedge CLK);
    checks++;
    if (TX !== 1'b0) begin errors++; $display("FAIL reset_mid_tx_active: got %b, want 0", TX); end
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    checks += 3;
    if (TX !== 1'b1) begin errors++; $display("FAIL reset_mid_tx: got %b, want 1", TX); end
    if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b, want 0", BUSY); end
    if (INPUTS_STATE !== 14'h0) begin errors++; $display("FAIL reset_mid_inputs: got %h, want 0000", INPUTS_STATE); end
    @(negedge CLK);
    RST_N = 1'b1;
    idle_bits(15);
    checks++;
    if (TX !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: got tx=%b busy=%b, want 1/0", TX, BUSY); end
    mon_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_settle();
    test_frame_err();
    test_timeout();
    test_random();
    test_coalesce();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
